// File: rtl/key_pkg.sv
// Shared types and constants for the key debouncer: per-key FSM state
// encoding, event type bits and the event-code width helper.
package key_pkg;

    typedef enum logic [1:0] {
        UP     = 2'd0,
        UP_CHK = 2'd1,
        DOWN   = 2'd2,
        DN_CHK = 2'd3
    } key_state_t;

    localparam logic EVT_PRESS   = 1'b1;
    localparam logic EVT_RELEASE = 1'b0;

    localparam int unsigned STAB_W = 4;

    // Event code is {press/release flag, key index}.
    function automatic int unsigned evt_code_width(input int unsigned num_keys);
        return 1 + $clog2(num_keys);
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One debounced key: two-flop synchroniser, UP/UP_CHK/DOWN/DN_CHK FSM that
// advances on sample ticks, registered level and one-cycle press/release strobes.
module key_debounce_cell
    import key_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 4
)
(
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    input  logic i_sample_tick,
    output logic o_key_down,
    output logic o_key_press,
    output logic o_key_release,
    output logic o_fire_press,
    output logic o_fire_release
);

    localparam logic [STAB_W-1:0] STAB_TGT = STAB_W'(STABLE_CNT);

    logic [1:0]        r_sync;
    logic              w_key_s;
    key_state_t        r_state;
    key_state_t        w_state_nxt;
    logic [STAB_W-1:0] r_stab;
    logic [STAB_W-1:0] w_stab_nxt;
    logic [STAB_W-1:0] w_stab_inc;
    logic              w_press;
    logic              w_release;
    logic              r_key_down;
    logic              r_key_press;
    logic              r_key_release;

    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // a blocking = here would let r_sync[1] see the new r_sync[0] in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_key_n};
        end
    end

    assign w_key_s    = ~r_sync[1];
    assign w_stab_inc = r_stab + STAB_W'(1);

    // NOTE: every output of this block gets a default first, otherwise the
    // paths that leave it unassigned would infer latches.
    always_comb begin
        w_state_nxt = r_state;
        w_stab_nxt  = r_stab;
        w_press     = 1'b0;
        w_release   = 1'b0;
        if (i_sample_tick) begin
            case (r_state)
                UP: begin
                    if (w_key_s) begin
                        if (STABLE_CNT == 1) begin
                            w_state_nxt = DOWN;
                            w_stab_nxt  = '0;
                            w_press     = 1'b1;
                        end else begin
                            w_state_nxt = UP_CHK;
                            w_stab_nxt  = STAB_W'(1);
                        end
                    end
                end
                UP_CHK: begin
                    if (!w_key_s) begin
                        w_state_nxt = UP;
                        w_stab_nxt  = '0;
                    end else if (w_stab_inc == STAB_TGT) begin
                        w_state_nxt = DOWN;
                        w_stab_nxt  = '0;
                        w_press     = 1'b1;
                    end else begin
                        w_stab_nxt  = w_stab_inc;
                    end
                end
                DOWN: begin
                    if (!w_key_s) begin
                        if (STABLE_CNT == 1) begin
                            w_state_nxt = UP;
                            w_stab_nxt  = '0;
                            w_release   = 1'b1;
                        end else begin
                            w_state_nxt = DN_CHK;
                            w_stab_nxt  = STAB_W'(1);
                        end
                    end
                end
                DN_CHK: begin
                    if (w_key_s) begin
                        w_state_nxt = DOWN;
                        w_stab_nxt  = '0;
                    end else if (w_stab_inc == STAB_TGT) begin
                        w_state_nxt = UP;
                        w_stab_nxt  = '0;
                        w_release   = 1'b1;
                    end else begin
                        w_stab_nxt  = w_stab_inc;
                    end
                end
                default: begin
                    w_state_nxt = UP;
                    w_stab_nxt  = '0;
                end
            endcase
        end
    end

    // Level and strobes are registered off the next state so they move on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= UP;
            r_stab        <= '0;
            r_key_down    <= 1'b0;
            r_key_press   <= 1'b0;
            r_key_release <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_stab        <= w_stab_nxt;
            r_key_down    <= (w_state_nxt == DOWN) || (w_state_nxt == DN_CHK);
            r_key_press   <= w_press;
            r_key_release <= w_release;
        end
    end

    assign o_key_down     = r_key_down;
    assign o_key_press    = r_key_press;
    assign o_key_release  = r_key_release;
    assign o_fire_press   = w_press;
    assign o_fire_release = w_release;

endmodule

// File: rtl/key_debouncer.sv
// Debounces NUM_KEYS active-low keys and queues press/release events into a
// small FIFO drained over a valid/ready handshake.
module key_debouncer
    import key_pkg::*;
#(
    parameter  int unsigned NUM_KEYS   = 4,
    parameter  int unsigned SAMPLE_DIV = 50000,
    parameter  int unsigned STABLE_CNT = 4,
    parameter  int unsigned EVT_DEPTH  = 4,
    localparam int unsigned CODE_W     = evt_code_width(NUM_KEYS)
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [CODE_W-1:0]   evt_code,
    output logic                evt_overflow
);

    localparam int unsigned IDX_W = CODE_W - 1;
    localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);
    localparam int unsigned PTR_W = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(EVT_DEPTH + 1);

    logic [DIV_W-1:0]    r_div_cnt;
    logic                w_sample_tick;
    logic [NUM_KEYS-1:0] w_fire_press;
    logic [NUM_KEYS-1:0] w_fire_release;
    logic [NUM_KEYS-1:0] r_pend;
    logic [NUM_KEYS-1:0] r_pend_type;
    logic [NUM_KEYS-1:0] w_sel_mask;
    logic [IDX_W-1:0]    w_sel_idx;
    logic                w_sel_valid;
    logic [CODE_W-1:0]   w_push_code;
    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic [CODE_W-1:0]   r_mem [EVT_DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_overflow;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(EVT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_sample_tick = (r_div_cnt == DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_sample_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_cell
        key_debounce_cell #(
            .STABLE_CNT (STABLE_CNT)
        ) u_cell (
            .clk            (clk),
            .rst            (rst),
            .i_key_n        (key_n[gi]),
            .i_sample_tick  (w_sample_tick),
            .o_key_down     (key_down[gi]),
            .o_key_press    (key_press[gi]),
            .o_key_release  (key_release[gi]),
            .o_fire_press   (w_fire_press[gi]),
            .o_fire_release (w_fire_release[gi])
        );
    end

    // Lowest-index pending key wins; one event leaves the pending set per cycle.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        w_sel_mask  = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (r_pend[i] && !w_sel_valid) begin
                w_sel_valid   = 1'b1;
                w_sel_idx     = IDX_W'(i);
                w_sel_mask[i] = 1'b1;
            end
        end
    end

    assign w_push_code = {r_pend_type[w_sel_idx], w_sel_idx};
    assign w_pop       = evt_valid & evt_ready;
    assign w_push      = w_sel_valid && ((r_count < CNT_W'(EVT_DEPTH)) || w_pop);
    assign w_drop      = w_sel_valid && !w_push;

    // A selected event leaves pend whether it was queued or dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend      <= '0;
            r_pend_type <= '0;
        end else begin
            r_pend <= (r_pend & ~w_sel_mask) | w_fire_press | w_fire_release;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (w_fire_press[i]) begin
                    r_pend_type[i] <= EVT_PRESS;
                end else if (w_fire_release[i]) begin
                    r_pend_type[i] <= EVT_RELEASE;
                end
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define which entries are meaningful, and evt_code is masked when empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign evt_valid    = (r_count != '0);
    assign evt_code     = evt_valid ? r_mem[r_rptr] : '0;
    assign evt_overflow = r_overflow;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with SAMPLE_DIV=4, STABLE_CNT=3, four keys
// and a four-deep event FIFO.
module tb_key_debouncer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_n;
    logic [3:0] key_down;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_code;
    logic       evt_overflow;

    int n_vec  = 0;
    int n_miss = 0;

    logic [2:0] q[$];
    int         qt[$];
    int         cyc = 0;
    int         press_cnt[4];
    int         rel_cnt[4];
    int         kd0_cyc = 0;
    int         valid_cyc = 0;

    key_debouncer #(
        .NUM_KEYS   (4),
        .SAMPLE_DIV (4),
        .STABLE_CNT (3),
        .EVT_DEPTH  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_n        (key_n),
        .key_down     (key_down),
        .key_press    (key_press),
        .key_release  (key_release),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_overflow (evt_overflow)
    );

    always #5 clk = ~clk;

    // Monitor on the falling edge: logs handshakes (a pop happens at the next rise) and strobe cycles.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (evt_valid && evt_ready) begin
                q.push_back(evt_code);
                qt.push_back(cyc);
            end
            for (int i = 0; i < 4; i++) begin
                if (key_press[i])   press_cnt[i]++;
                if (key_release[i]) rel_cnt[i]++;
            end
            if (key_down[0]) kd0_cyc++;
            if (evt_valid)   valid_cyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] ev(input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return 3'bxxx;
    endfunction

    function automatic int gap(input int i);
        if (i >= 1 && i < qt.size()) return qt[i] - qt[i-1];
        return -1;
    endfunction

    initial begin
        int qb;
        int pb;
        int rb;
        int kb;
        int vb;

        rst       = 1'b1;
        key_n     = 4'hF;
        evt_ready = 1'b0;
        step(3);
        rst = 1'b0;
        check("rst_key_down",     32'(key_down),     32'h0);
        check("rst_key_press",    32'(key_press),    32'h0);
        check("rst_key_release",  32'(key_release),  32'h0);
        check("rst_evt_valid",    32'(evt_valid),    32'h0);
        check("rst_evt_code",     32'(evt_code),     32'h0);
        check("rst_evt_overflow", 32'(evt_overflow), 32'h0);

        // Key 1 held long enough to be accepted, then released.
        evt_ready = 1'b1;
        qb = q.size(); pb = press_cnt[1]; rb = rel_cnt[1];
        key_n = 4'b1101;
        step(40);
        check("t1_press_cycles", press_cnt[1] - pb, 1);
        check("t1_key_down",     32'(key_down), 32'h2);
        check("t1_evt_count",    q.size() - qb, 1);
        check("t1_evt_press",    32'(ev(qb)), 32'h5);       // 3'b101
        key_n = 4'hF;
        step(40);
        check("t1_release_cycles", rel_cnt[1] - rb, 1);
        check("t1_key_up",         32'(key_down), 32'h0);
        check("t1_evt_count2",     q.size() - qb, 2);
        check("t1_evt_release",    32'(ev(qb + 1)), 32'h1); // 3'b001

        // Key 0 bouncing with 5-cycle spans never sees 3 agreeing samples.
        qb = q.size(); pb = press_cnt[0]; rb = rel_cnt[0];
        kb = kd0_cyc; vb = valid_cyc;
        for (int k = 0; k < 3; k++) begin
            key_n[0] = 1'b0;
            step(5);
            key_n[0] = 1'b1;
            step(5);
        end
        step(20);
        check("t2_no_press",   press_cnt[0] - pb, 0);
        check("t2_no_release", rel_cnt[0] - rb, 0);
        check("t2_never_down", kd0_cyc - kb, 0);
        check("t2_never_valid", valid_cyc - vb, 0);
        check("t2_no_events",  q.size() - qb, 0);

        // Keys 0 and 2 together: lowest index first, on consecutive cycles.
        qb = q.size();
        key_n = 4'b1010;
        step(40);
        check("t3_evt_count", q.size() - qb, 2);
        check("t3_evt0",      32'(ev(qb)),     32'h4);      // 3'b100
        check("t3_evt1",      32'(ev(qb + 1)), 32'h6);      // 3'b110
        check("t3_gap",       gap(qb + 1), 1);
        key_n = 4'hF;
        step(40);
        check("t3_evt_count2", q.size() - qb, 4);
        check("t3_evt2",       32'(ev(qb + 2)), 32'h0);     // 3'b000
        check("t3_evt3",       32'(ev(qb + 3)), 32'h2);     // 3'b010

        // Consumer stalled: six events, only the first four are kept.
        evt_ready = 1'b0;
        key_n = 4'b1000;
        step(40);
        check("t4_no_ovf_yet", 32'(evt_overflow), 32'h0);
        check("t4_valid_a",    32'(evt_valid),    32'h1);
        check("t4_head_a",     32'(evt_code),     32'h4);
        key_n = 4'hF;
        step(40);
        check("t4_overflow",   32'(evt_overflow), 32'h1);
        check("t4_valid_b",    32'(evt_valid),    32'h1);
        check("t4_head_b",     32'(evt_code),     32'h4);
        check("t4_key_down",   32'(key_down),     32'h0);
        qb = q.size();
        evt_ready = 1'b1;
        step(10);
        check("t4_drain_count", q.size() - qb, 4);
        check("t4_drain0",      32'(ev(qb)),     32'h4);
        check("t4_drain1",      32'(ev(qb + 1)), 32'h5);
        check("t4_drain2",      32'(ev(qb + 2)), 32'h6);
        check("t4_drain3",      32'(ev(qb + 3)), 32'h0);
        check("t4_empty",       32'(evt_valid),    32'h0);
        check("t4_ovf_sticky",  32'(evt_overflow), 32'h1);

        // Key 3 held, reset mid-check, then exactly 3 fresh samples to accept.
        key_n = 4'b0111;
        step(8);
        check("t5_mid_chk", 32'(key_down), 32'h0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t5_rst_key_down",    32'(key_down),     32'h0);
        check("t5_rst_key_press",   32'(key_press),    32'h0);
        check("t5_rst_key_release", 32'(key_release),  32'h0);
        check("t5_rst_valid",       32'(evt_valid),    32'h0);
        check("t5_rst_code",        32'(evt_code),     32'h0);
        check("t5_rst_overflow",    32'(evt_overflow), 32'h0);
        step(11);
        check("t5_not_yet",   32'(key_down),  32'h0);
        step(1);
        check("t5_key_down",  32'(key_down),  32'h8);
        check("t5_key_press", 32'(key_press), 32'h8);
        step(1);
        check("t5_press_end", 32'(key_press), 32'h0);
        check("t5_valid",     32'(evt_valid), 32'h1);
        check("t5_code",      32'(evt_code),  32'h7);       // 3'b111
        key_n = 4'hF;
        step(40);
        check("t5_released", 32'(key_down), 32'h0);

        // Full FIFO with a pop and a push landing on the same edge.
        evt_ready = 1'b0;
        key_n = 4'h0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(16);
        check("t6_all_down", 32'(key_down),     32'hF);
        check("t6_full_hd",  32'(evt_code),     32'h4);
        check("t6_full_ovf", 32'(evt_overflow), 32'h0);
        key_n = 4'b0001;
        step(12);
        check("t6_release_strobe", 32'(key_release),  32'h1);
        check("t6_pre_ovf",        32'(evt_overflow), 32'h0);
        qb = q.size();
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        check("t6_one_pop",  q.size() - qb, 1);
        check("t6_popped",   32'(ev(qb)), 32'h4);
        check("t6_no_ovf",   32'(evt_overflow), 32'h0);
        check("t6_valid",    32'(evt_valid), 32'h1);
        check("t6_new_head", 32'(evt_code),  32'h5);
        qb = q.size();
        evt_ready = 1'b1;
        step(10);
        check("t6_drain_count", q.size() - qb, 4);
        check("t6_drain0",      32'(ev(qb)),     32'h5);
        check("t6_drain1",      32'(ev(qb + 1)), 32'h6);
        check("t6_drain2",      32'(ev(qb + 2)), 32'h7);
        check("t6_drain3",      32'(ev(qb + 3)), 32'h0);
        check("t6_empty",       32'(evt_valid),    32'h0);
        check("t6_ovf_clear",   32'(evt_overflow), 32'h0);
        key_n = 4'hF;
        step(40);
        check("t6_final_count", q.size() - qb, 7);
        check("t6_final0",      32'(ev(qb + 4)), 32'h1);
        check("t6_final1",      32'(ev(qb + 5)), 32'h2);
        check("t6_final2",      32'(ev(qb + 6)), 32'h3);
        check("t6_final_up",    32'(key_down), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
